// File: rtl/tx_scrambler.sv
// Transmit-lane scrambler for 8b/10b (Gen1/2) and 128b/130b (Gen3+) link rates.
// Every output is registered one cycle after its input beat; there is no backpressure.
module tx_scrambler #(
  parameter logic [22:0] LANE_SEED = 23'h1DBFBC
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [2:0]  generation,
  input  logic [31:0] inData,
  input  logic [3:0]  inDataK,
  input  logic [1:0]  inSyncHeader,
  input  logic        inDataValid,
  output logic [31:0] scramblerDataOut,
  output logic [3:0]  scramblerDataK,
  output logic [1:0]  scramblerSyncHeader,
  output logic        scramblerDataValid,
  output logic        blockAlignErr
);

  localparam logic [15:0] G12_INIT = 16'hFFFF;
  localparam logic [7:0]  SYM_COM  = 8'hBC;
  localparam logic [7:0]  SYM_SKP  = 8'h1C;
  localparam logic [7:0]  OS_SKP   = 8'hAA;
  localparam logic [7:0]  OS_EIEOS = 8'h00;

  localparam logic [1:0] BLK_DATA  = 2'd0;
  localparam logic [1:0] BLK_SKP   = 2'd1;
  localparam logic [1:0] BLK_EIEOS = 2'd2;
  localparam logic [1:0] BLK_OS    = 2'd3;

  // Eight Galois steps; returns {next_state, key_byte} with key bit i from step i.
  function automatic logic [23:0] step16x8(input logic [15:0] seed);
    logic [15:0] s;
    logic [7:0]  key;
    s   = seed;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      key[i] = s[15];
      s      = {s[14:0], s[15]} ^ ({16{s[15]}} & 16'h0038);
    end
    return {s, key};
  endfunction

  function automatic logic [30:0] step23x8(input logic [22:0] seed);
    logic [22:0] s;
    logic [7:0]  key;
    s   = seed;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      key[i] = s[22];
      s      = {s[21:0], s[22]} ^ ({23{s[22]}} & 23'h210124);
    end
    return {s, key};
  endfunction

  logic [2:0]  gen_q;
  logic [15:0] lfsr16_q, lfsr16_d;
  logic [22:0] lfsr23_q, lfsr23_d;
  logic [2:0]  beat_q, beat_d;
  logic [1:0]  blk_q, blk_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  k_q, k_d;
  logic [1:0]  sync_q, sync_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        gen_change;
  logic [15:0] lfsr16_cur;
  logic [22:0] lfsr23_cur, lfsr23_w;
  logic [2:0]  beat_cur, beat_eff, last_beat, nbytes;
  logic [1:0]  blk_eff;
  logic        hdr_ok;
  logic [23:0] st16;
  logic [30:0] st23;

  always_comb begin
    // A rate change restarts both scramblers and the block framing on this very beat.
    gen_change = (generation != gen_q);
    lfsr16_cur = gen_change ? G12_INIT  : lfsr16_q;
    lfsr23_cur = gen_change ? LANE_SEED : lfsr23_q;
    beat_cur   = gen_change ? 3'd0      : beat_q;

    lfsr16_d  = lfsr16_cur;
    lfsr23_d  = lfsr23_cur;
    beat_d    = beat_cur;
    blk_d     = blk_q;
    data_d    = '0;
    k_d       = '0;
    sync_d    = '0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    nbytes    = (generation == 3'd3) ? 3'd2 : 3'd4;
    last_beat = (generation == 3'd3) ? 3'd7 : 3'd3;
    beat_eff  = beat_cur;
    blk_eff   = blk_q;
    hdr_ok    = 1'b1;
    lfsr23_w  = lfsr23_cur;
    st16      = step16x8(lfsr16_cur);
    st23      = '0;

    case (generation)
      3'd1, 3'd2: begin
        if (inDataValid) begin
          valid_d     = 1'b1;
          k_d         = inDataK;
          sync_d      = inSyncHeader;
          data_d[7:0] = inData[7:0];
          if (inDataK[0] && inData[7:0] == SYM_COM) begin
            lfsr16_d = G12_INIT;
          end else if (!(inDataK[0] && inData[7:0] == SYM_SKP)) begin
            lfsr16_d = st16[23:8];
            if (!inDataK[0]) data_d[7:0] = inData[7:0] ^ st16[7:0];
          end
        end
      end
      3'd3, 3'd4, 3'd5: begin
        if (inDataValid) begin
          valid_d = 1'b1;
          k_d     = inDataK;
          sync_d  = inSyncHeader;
          // A header mid-block means the far end re-framed; follow it from beat 0.
          if (inSyncHeader != 2'b00 && beat_cur != 3'd0) begin
            err_d    = 1'b1;
            beat_eff = 3'd0;
          end
          if (beat_eff == 3'd0) begin
            case (inSyncHeader)
              2'b10:   blk_eff = BLK_DATA;
              2'b01:   blk_eff = (inData[7:0] == OS_SKP)   ? BLK_SKP :
                                 (inData[7:0] == OS_EIEOS) ? BLK_EIEOS : BLK_OS;
              default: hdr_ok = 1'b0;
            endcase
          end
          for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes) begin
              st23 = step23x8(lfsr23_w);
              data_d[8*b +: 8] = inData[8*b +: 8] ^
                                 ((hdr_ok && blk_eff == BLK_DATA) ? st23[7:0] : 8'h00);
              if (hdr_ok && (blk_eff == BLK_DATA || blk_eff == BLK_OS)) lfsr23_w = st23[30:8];
            end
          end
          if (hdr_ok) begin
            blk_d    = blk_eff;
            beat_d   = (beat_eff == last_beat) ? 3'd0 : beat_eff + 3'd1;
            lfsr23_d = (blk_eff == BLK_EIEOS && beat_eff == last_beat) ? LANE_SEED : lfsr23_w;
          end else begin
            err_d  = 1'b1;
            beat_d = beat_eff;
          end
        end
      end
      default: begin
        lfsr16_d = G12_INIT;
        lfsr23_d = LANE_SEED;
        beat_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      gen_q    <= 3'd0;
      lfsr16_q <= G12_INIT;
      lfsr23_q <= LANE_SEED;
      beat_q   <= 3'd0;
      blk_q    <= BLK_DATA;
      data_q   <= '0;
      k_q      <= '0;
      sync_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      gen_q    <= generation;
      lfsr16_q <= lfsr16_d;
      lfsr23_q <= lfsr23_d;
      beat_q   <= beat_d;
      blk_q    <= blk_d;
      data_q   <= data_d;
      k_q      <= k_d;
      sync_q   <= sync_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign scramblerDataOut    = data_q;
  assign scramblerDataK      = k_q;
  assign scramblerSyncHeader = sync_q;
  assign scramblerDataValid  = valid_q;
  assign blockAlignErr       = err_q;

endmodule
